pool1d_stream: RTL and testbench
================================

Name: pool1d_stream

Overview:
- Streaming 1-D temporal pooling stage for the keyword-spotting feature/CNN pipeline.
- Consumes one frame of CHANNELS signed samples per handshake beat and emits one pooled frame per window. Pooling is MAX or AVG, selected at run time.
- Successor to the fixed-size max-pool: parametrised width, channel count, kernel and stride; adds valid/ready back-pressure, signed arithmetic, average mode and sequence-boundary handling.
- Sits between a conv1d/activation stage and the next layer.

Parameters:
- DATA_WIDTH, 16, bits per signed sample.
- CHANNELS, 32, samples per frame.
- KERNEL, 2, frames per pooling window; power of 2, >=1.
- STRIDE, 2, frames between window starts; STRIDE >= KERNEL. Frames at phase KERNEL..STRIDE-1 are consumed and ignored.
- KLOG2, $clog2(KERNEL), derived; accumulator growth bits.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cfg_mode  input  1  0 = MAX, 1 = AVG; sampled at window start
- in_valid  input  1  input frame valid
- in_ready  output  1  block accepts frame this cycle
- in_data  input  CHANNELS*DATA_WIDTH  frame; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- in_last  input  1  frame is last of sequence
- out_valid  output  1  pooled frame valid
- out_ready  input  1  downstream accepts
- out_data  output  CHANNELS*DATA_WIDTH  pooled frame, same packing
- drop_pulse  output  1  one-cycle pulse when a partial window is discarded

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: out_valid=0, out_data=0, drop_pulse=0, phase=0, accumulators=0, latched mode=MAX. in_ready is combinational from state; it is 1 after reset.
- Accept: a frame is taken when in_valid && in_ready.
- phase counter runs 0..STRIDE-1 and wraps to 0. It advances on each accepted frame.
- Window start: phase==0. Latch cfg_mode; each accumulator acc[c] loads the sign-extended sample.
- phase 1..KERNEL-1:
  - MAX: acc[c] = signed max(acc[c], sample).
  - AVG: acc[c] += sign-extended sample. Width is DATA_WIDTH+KLOG2, so no overflow is possible.
- Emit: on accepting the frame at phase==KERNEL-1, the cycle after the accept gives out_valid=1 and out_data[c] = MAX ? acc_final : acc_final >>> KLOG2.
  - The shift is arithmetic and floors toward minus infinity.
  - Latency is one cycle from the last window frame to out_valid.
  - KERNEL=1 gives an identity copy; in AVG mode the shift is 0.
- Output holding: out_data is held stable while out_valid && !out_ready. out_valid drops after the handshake unless a new emit lands in the same cycle.
- Back-pressure: in_ready = !(phase==KERNEL-1 && out_valid && !out_ready). Only the window-completing frame stalls; accumulating and skipped frames flow freely.
- Simultaneous events: a downstream handshake and a new emit in the same cycle are allowed. out_valid stays 1 and out_data is updated with no bubble.
- in_last behaviour:
  - Phase resets to 0 after the frame.
  - If that frame completes a window (phase==KERNEL-1), emit normally.
  - If the window is incomplete (phase < KERNEL-1), discard the partial accumulation and pulse drop_pulse the next cycle.
  - If phase >= KERNEL, it is a skip frame: reset phase only, with no pulse.
- cfg_mode changes mid-window have no effect until the next window start.
- Reset mid-operation: everything clears immediately, including a pending out_valid. Downstream sees the frame vanish.

Decomposition:
- Package pool_pkg:
  - localparam POOL_MAX=1'b0, POOL_AVG=1'b1.
  - Function for signed max.
  - Packing helper for lane extraction.
- One natural sub-module, pool_lane: per-channel accumulator with load/update/mode and result output. It is instantiated CHANNELS times via generate.
- The top level holds the phase counter, handshake and output register.

Test Plan:
- MAX, K=2 S=2, CH=2, DW=16, frames {3,-5},{7,-9} -> one output {7,-5}, out_valid one cycle after the second accept.
- AVG, K=4 S=4, lane0 frames 1,2,3,-1 -> sum 5, out 1. Lane1 frames -1,-1,-1,-2 -> sum -5, out -2 (floor).
- Extremes, DW=16 AVG K=2: 32767+32767 -> 32767 and -32768+-32768 -> -32768, with no overflow.
- Back-pressure: hold out_ready=0 with an output pending. The next window's accumulating frame is accepted, but the completing frame stalls (in_ready=0) with out_data stable. Raise out_ready -> both outputs appear in order with no loss.
- K=2 S=3: frames 1..6 on lane0 MAX -> outputs 2, 5; frames 3 and 6 ignored.
- in_last on frame 3 of K=2 S=2 (phase 0) -> drop_pulse=1 for one cycle, no output. Next frames 10,20 -> output 20. Additionally assert rst_n low while out_valid=1 -> out_valid=0 immediately and in_ready=1 after release.

Source files
------------

// File: rtl/pool1d_stream_pkg.sv
// Shared constants and helpers for the 1-D temporal pooling stage.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Wide enough to hold any lane accumulator without loss.
  localparam int ACC_W = 64;

  function automatic logic signed [ACC_W-1:0] smax(input logic signed [ACC_W-1:0] a,
                                                   input logic signed [ACC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pool1d_stream_if.sv
// Frame-in / pooled-frame-out handshake bundle for pool1d_stream.
interface pool1d_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 32
) ();

  logic                           in_valid;
  logic                           in_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] in_data;
  logic                           in_last;
  logic                           out_valid;
  logic                           out_ready;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pool1d_stream_lane.sv
// One channel of the pooling datapath: window accumulator plus final scaling.
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int KLOG2      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_i,
  input  logic                         update_i,
  input  logic                         clr_i,
  input  logic                         mode_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  output logic        [DATA_WIDTH-1:0] result_o
);

  localparam int AW = DATA_WIDTH + KLOG2;

  logic signed [AW-1:0] acc_q, acc_d, sample_ext;

  assign sample_ext = AW'(sample_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = sample_ext;
    end else if (update_i) begin
      if (mode_i == POOL_AVG) begin
        acc_d = acc_q + sample_ext;
      end else begin
        acc_d = AW'(smax(ACC_W'(acc_q), ACC_W'(sample_ext)));
      end
    end
  end

  // Result reflects the frame being accepted this cycle, so the top can
  // register it directly on the window-completing beat.
  always_comb begin
    if (mode_i == POOL_AVG) begin
      result_o = DATA_WIDTH'(acc_d >>> KLOG2);
    end else begin
      result_o = DATA_WIDTH'(acc_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pool1d_stream.sv
// Streaming 1-D MAX/AVG pooling over frames of CHANNELS signed samples,
// with valid/ready back-pressure and sequence-boundary handling.
module pool1d_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 32,
  parameter int KERNEL     = 2,
  parameter int STRIDE     = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_mode,
  pool1d_stream_if.slave bus,
  output logic           drop_pulse
);

  localparam int KLOG2 = $clog2(KERNEL);
  localparam int PW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int BW    = CHANNELS * DATA_WIDTH;
  localparam logic [PW-1:0] PH_KEND = PW'(KERNEL - 1);
  localparam logic [PW-1:0] PH_SEND = PW'(STRIDE - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          mode_q, mode_d, mode_eff;
  logic          out_valid_q, out_valid_d;
  logic          drop_q, drop_d;
  logic [BW-1:0] out_data_q, out_data_d, result;
  logic          win_start, win_end, in_kernel, partial, stall, accept;
  logic          lane_load, lane_update, lane_clr;

  assign win_start = (phase_q == '0);
  assign win_end   = (phase_q == PH_KEND);
  assign in_kernel = (int'(phase_q) < KERNEL);
  assign partial   = (int'(phase_q) < KERNEL - 1);

  // Only the window-completing frame waits on a pending, unaccepted output.
  assign stall        = win_end && out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;
  assign accept       = bus.in_valid && !stall;

  assign mode_eff    = win_start ? cfg_mode : mode_q;
  assign lane_load   = accept && win_start;
  assign lane_update = accept && !win_start && in_kernel;
  assign lane_clr    = accept && bus.in_last && partial;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .KLOG2      (KLOG2)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (lane_load),
      .update_i (lane_update),
      .clr_i    (lane_clr),
      .mode_i   (mode_eff),
      .sample_i (bus.in_data[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
      .result_o (result[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  always_comb begin
    phase_d     = phase_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    drop_d      = 1'b0;
    if (accept) begin
      if (win_start) begin
        mode_d = cfg_mode;
      end
      if (bus.in_last || (phase_q == PH_SEND)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PW'(1);
      end
      if (win_end) begin
        out_valid_d = 1'b1;
        out_data_d  = result;
      end
      drop_d = bus.in_last && partial;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      mode_q      <= POOL_MAX;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign drop_pulse    = drop_q;

endmodule

// File: tb/tb_pool1d_stream.sv
// Randomized scoreboard bench for pool1d_stream (K=4, S=6, 4 lanes of 16 bits).
module tb_pool1d_stream;

  localparam int DW = 16;
  localparam int CH = 4;
  localparam int K  = 4;
  localparam int S  = 6;
  localparam int W  = CH * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_mode = 1'b0;
  logic drop_pulse;

  pool1d_stream_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

  pool1d_stream #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .KERNEL     (K),
    .STRIDE     (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_mode   (cfg_mode),
    .bus        (bus),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];
  int   vectors = 0;
  int   errs = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;

  // Reference model state: frames of the current window, latched mode, phase.
  int   m_ph = 0;
  bit   m_mode = 1'b0;
  int   win[K][CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] fr(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [W-1:0] model_result();
    logic [W-1:0] res = '0;
    for (int c = 0; c < CH; c++) begin
      int r;
      int sum;
      if (m_mode == 1'b0) begin
        r = win[0][c];
        for (int i = 1; i < K; i++) if (win[i][c] > r) r = win[i][c];
      end else begin
        sum = 0;
        for (int i = 0; i < K; i++) sum += win[i][c];
        r = sum / K;
        if ((sum % K) != 0 && sum < 0) r -= 1;
      end
      res[c*DW +: DW] = DW'(r);
    end
    return res;
  endfunction

  task automatic model_accept(input logic [W-1:0] d, input bit m, input bit l);
    logic signed [DW-1:0] s;
    if (m_ph == 0) m_mode = m;
    if (m_ph < K) begin
      for (int c = 0; c < CH; c++) begin
        s = d[c*DW +: DW];
        win[m_ph][c] = int'(s);
      end
    end
    if (m_ph == K - 1) exp_q.push_back('{model_result(), cyc + 1});
    if (l && m_ph < K - 1) drop_q.push_back(cyc + 1);
    m_ph = l ? 0 : (m_ph + 1) % S;
  endtask

  task automatic model_reset();
    m_ph = 0;
    m_mode = 1'b0;
    exp_q.delete();
    drop_q.delete();
  endtask

  task automatic step(input logic [W-1:0] d, input bit v, input bit m, input bit l,
                      input bit r, output bit acc);
    bit exp_rdy;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = r;
    cfg_mode      = m;
    #1;
    exp_rdy = !(m_ph == K - 1 && exp_q.size() != 0 && !r);
    if (chk_en) chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    acc = v && bus.in_ready;
    if (acc) model_accept(d, m, l);
  endtask

  task automatic send(input logic [W-1:0] d, input bit m, input bit l, input bit r);
    bit acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) step(d, 1'b1, m, l, r, acc);
    if (!acc) begin
      vectors++;
      errs++;
      $display("FAIL send_timeout: frame %h never accepted", d);
    end
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0, r, acc);
  endtask

  // Monitor: samples just before each rising edge and pops on handshakes.
  initial begin
    bit prev_hold = 1'b0;
    bit exp_drop;
    forever begin
      @(negedge clk);
      #2;
      if (!chk_en) begin
        prev_hold = 1'b0;
        continue;
      end
      exp_drop = (drop_q.size() != 0) && (drop_q[0] == cyc);
      if (exp_drop) void'(drop_q.pop_front());
      if (drop_pulse || exp_drop) chk("drop_pulse", 64'(drop_pulse), 64'(exp_drop));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL spurious_out: out_valid with data %h, expected no output", bus.out_data);
        end else begin
          chk("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
          if (!prev_hold) chk("out_latency", 64'(cyc), 64'(exp_q[0].due));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        vectors++;
        errs++;
        $display("FAIL missing_out: out_valid 0, expected data %h due cycle %0d", exp_q[0].data, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      prev_hold = bus.out_valid && !bus.out_ready;
    end
  end

  initial begin
    bit acc;
    logic [W-1:0] d;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_drop", 64'(drop_pulse), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    rst_n = 1'b1;
    chk_en = 1'b1;

    // MAX window, then two skip frames carrying a different mode
    send(fr(3, -5, 100, -1), 1'b0, 1'b0, 1'b1);
    send(fr(7, -9, -100, -1), 1'b0, 1'b0, 1'b1);
    send(fr(1, -6, 0, -32768), 1'b0, 1'b0, 1'b1);
    send(fr(-2, -20, 32767, -2), 1'b0, 1'b0, 1'b1);
    send(fr(999, 999, 999, 999), 1'b1, 1'b0, 1'b1);
    send(fr(888, 888, 888, 888), 1'b1, 1'b0, 1'b1);
    idle(2, 1'b1);

    // AVG window with floor and extremes; cfg_mode flips mid-window
    send(fr(1, -1, 32767, -32768), 1'b1, 1'b0, 1'b1);
    send(fr(2, -1, 32767, -32768), 1'b0, 1'b0, 1'b1);
    send(fr(3, -1, 32767, -32768), 1'b0, 1'b0, 1'b1);
    send(fr(-1, -2, 32767, -32768), 1'b0, 1'b0, 1'b1);
    send(fr(5, 5, 5, 5), 1'b0, 1'b0, 1'b1);
    send(fr(6, 6, 6, 6), 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Back-pressure: second window's completing frame must stall
    for (int i = 0; i < S; i++) send(fr(i, -i, 10 * i, 7), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < K - 1; i++) send(fr(20 + i, -30, i, 1), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(fr(50, 51, 52, 53), 1'b1, 1'b1, 1'b0, 1'b0, acc);
    send(fr(50, 51, 52, 53), 1'b1, 1'b0, 1'b1);
    send(fr(0, 0, 0, 0), 1'b0, 1'b0, 1'b1);
    send(fr(0, 0, 0, 0), 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // in_last: at phase 0 (drop), mid-window (drop), on skip (no drop), on completion
    send(fr(3, 3, 3, 3), 1'b0, 1'b1, 1'b1);
    send(fr(10, 1, 1, 1), 1'b0, 1'b0, 1'b1);
    send(fr(20, 2, 2, 2), 1'b0, 1'b0, 1'b1);
    send(fr(5, 3, 3, 3), 1'b0, 1'b0, 1'b1);
    send(fr(1, 4, 4, 4), 1'b0, 1'b0, 1'b1);
    send(fr(9, 9, 9, 9), 1'b0, 1'b1, 1'b1);
    send(fr(1, 1, 1, 1), 1'b1, 1'b0, 1'b1);
    send(fr(2, 2, 2, 2), 1'b1, 1'b0, 1'b1);
    send(fr(3, 3, 3, 3), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < K; i++) send(fr(i, i + 1, i + 2, i + 3), 1'b1, 1'b0, 1'b1);
    send(fr(7, 7, 7, 7), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < K; i++) send(fr(-i, 4, -4, i), 1'b0, i == K - 1, 1'b1);
    send(fr(11, 12, 13, 14), 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 7))
        0:       d = {CH{16'h7fff}};
        1:       d = {CH{16'h8000}};
        default: d = {$urandom(), $urandom()};
      endcase
      step(d, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, acc);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1, 1'b1);
    send(fr(0, 0, 0, 0), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1, 1'b1);
    idle(2, 1'b1);
    if (exp_q.size() != 0) begin
      vectors++;
      errs++;
      $display("FAIL drain_timeout: %0d outputs still expected", exp_q.size());
    end

    // Reset while an output is pending
    for (int i = 0; i < K; i++) send(fr(i, i, i, i), 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("pending_valid", 64'(bus.out_valid), 64'(1));
    @(negedge clk);
    chk_en = 1'b0;
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_out_data", 64'(bus.out_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("postrst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("postrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk_en = 1'b1;
    for (int i = 0; i < K; i++) send(fr(4 - i, i, -i, 100), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);
    if (exp_q.size() != 0) begin
      vectors++;
      errs++;
      $display("FAIL final_drain: %0d outputs still expected", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
